// File: rtl/imager_crop.sv
// Streaming window crop: keeps a rectangular region of each frame and reports
// the kept geometry of the last completed frame on out_cols/out_rows.
`ifndef DTYPE_WIDTH
`define DTYPE_WIDTH 4
`endif
`ifndef DTYPE_FRAME_START
`define DTYPE_FRAME_START  4'h1
`define DTYPE_FRAME_END    4'h2
`define DTYPE_ROW_START    4'h3
`define DTYPE_ROW_END      4'h4
`define DTYPE_PIXEL        4'h5
`define DTYPE_HEADER_START 4'h6
`define DTYPE_HEADER       4'h7
`define DTYPE_HEADER_END   4'h8
`endif

module imager_crop #(
  parameter int DATA_WIDTH = 16,
  parameter int DIM_WIDTH  = 16
) (
  input  logic                    clk,
  input  logic                    resetb,
  input  logic                    enable,
  input  logic [DIM_WIDTH-1:0]    col_start,
  input  logic [DIM_WIDTH-1:0]    row_start,
  input  logic [DIM_WIDTH-1:0]    num_cols,
  input  logic [DIM_WIDTH-1:0]    num_rows,
  input  logic                    dvi,
  input  logic [`DTYPE_WIDTH-1:0] dtypei,
  input  logic [DATA_WIDTH-1:0]   datai,
  output logic                    dvo,
  output logic [`DTYPE_WIDTH-1:0] dtypeo,
  output logic [DATA_WIDTH-1:0]   datao,
  output logic [DIM_WIDTH-1:0]    out_cols,
  output logic [DIM_WIDTH-1:0]    out_rows
);

  localparam logic [DIM_WIDTH-1:0] ONE = DIM_WIDTH'(1);

  logic                    r_en;
  logic [DIM_WIDTH-1:0]    r_col_start;
  logic [DIM_WIDTH-1:0]    r_row_start;
  logic [DIM_WIDTH-1:0]    r_num_cols;
  logic [DIM_WIDTH-1:0]    r_num_rows;
  logic                    r_in_frame;
  logic                    r_in_row;
  logic [DIM_WIDTH-1:0]    r_row_cnt;
  logic [DIM_WIDTH-1:0]    r_col_cnt;
  logic [DIM_WIDTH-1:0]    r_pix_cnt;
  logic [DIM_WIDTH-1:0]    r_kept_rows;
  logic [DIM_WIDTH-1:0]    r_last_cols;
  logic                    r_dvo;
  logic [`DTYPE_WIDTH-1:0] r_dtypeo;
  logic [DATA_WIDTH-1:0]   r_datao;
  logic [DIM_WIDTH-1:0]    r_out_cols;
  logic [DIM_WIDTH-1:0]    r_out_rows;

  logic [DIM_WIDTH:0]      w_row_lim;
  logic [DIM_WIDTH:0]      w_col_lim;
  logic                    w_win_ok;
  logic                    w_row_win;
  logic                    w_col_win;
  logic                    w_row_keep;
  logic                    w_pix_keep;
  logic                    w_open_kept;
  logic [DIM_WIDTH-1:0]    w_row_rel;
  logic [DATA_WIDTH-1:0]   w_rs_data;

  // Window limits are one bit wider so a window running past the top of the
  // counter range is clipped instead of wrapping back to row/column 0.
  assign w_row_lim   = {1'b0, r_row_start} + {1'b0, r_num_rows};
  assign w_col_lim   = {1'b0, r_col_start} + {1'b0, r_num_cols};
  assign w_win_ok    = (r_num_rows != '0) && (r_num_cols != '0);
  assign w_row_win   = w_win_ok && (r_row_cnt >= r_row_start) &&
                       ({1'b0, r_row_cnt} < w_row_lim);
  assign w_col_win   = w_win_ok && (r_col_cnt >= r_col_start) &&
                       ({1'b0, r_col_cnt} < w_col_lim);
  assign w_row_keep  = !r_en || w_row_win;
  assign w_pix_keep  = w_row_keep && (!r_en || w_col_win);
  assign w_open_kept = r_in_row && w_row_keep;
  assign w_row_rel   = r_row_cnt - r_row_start;
  assign w_rs_data   = r_en ? DATA_WIDTH'(w_row_rel) : datai;

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      r_en        <= 1'b0;
      r_col_start <= '0;
      r_row_start <= '0;
      r_num_cols  <= '0;
      r_num_rows  <= '0;
      r_in_frame  <= 1'b0;
      r_in_row    <= 1'b0;
      r_row_cnt   <= '0;
      r_col_cnt   <= '0;
      r_pix_cnt   <= '0;
      r_kept_rows <= '0;
      r_last_cols <= '0;
      r_dvo       <= 1'b0;
      r_dtypeo    <= '0;
      r_datao     <= '0;
      r_out_cols  <= '0;
      r_out_rows  <= '0;
    end else begin
      r_dvo    <= 1'b0;
      r_dtypeo <= '0;
      r_datao  <= '0;
      if (dvi) begin
        case (dtypei)
          `DTYPE_FRAME_START: begin
            r_dvo       <= 1'b1;
            r_dtypeo    <= dtypei;
            r_datao     <= datai;
            r_en        <= enable;
            r_col_start <= col_start;
            r_row_start <= row_start;
            r_num_cols  <= num_cols;
            r_num_rows  <= num_rows;
            r_in_frame  <= 1'b1;
            r_in_row    <= 1'b0;
            r_row_cnt   <= '0;
            r_col_cnt   <= '0;
            r_pix_cnt   <= '0;
            r_kept_rows <= '0;
            r_last_cols <= '0;
          end
          `DTYPE_FRAME_END: begin
            r_dvo    <= 1'b1;
            r_dtypeo <= dtypei;
            r_datao  <= datai;
            // An unterminated row is closed here as if its ROW_END had arrived.
            if (r_in_frame) begin
              r_out_cols <= w_open_kept ? r_pix_cnt : r_last_cols;
              r_out_rows <= r_kept_rows + (w_open_kept ? ONE : '0);
            end
            r_in_frame <= 1'b0;
            r_in_row   <= 1'b0;
          end
          `DTYPE_ROW_START: begin
            if (r_in_frame) begin
              r_col_cnt <= '0;
              r_pix_cnt <= '0;
              r_in_row  <= 1'b1;
              if (w_row_keep) begin
                r_dvo    <= 1'b1;
                r_dtypeo <= dtypei;
                r_datao  <= w_rs_data;
              end
            end
          end
          `DTYPE_ROW_END: begin
            if (r_in_frame) begin
              r_row_cnt <= r_row_cnt + ONE;
              r_in_row  <= 1'b0;
              if (w_row_keep) begin
                r_kept_rows <= r_kept_rows + ONE;
                r_last_cols <= r_pix_cnt;
                r_dvo       <= 1'b1;
                r_dtypeo    <= dtypei;
                r_datao     <= datai;
              end
            end
          end
          `DTYPE_PIXEL: begin
            if (r_in_frame) begin
              r_col_cnt <= r_col_cnt + ONE;
              if (w_pix_keep) begin
                r_pix_cnt <= r_pix_cnt + ONE;
                r_dvo     <= 1'b1;
                r_dtypeo  <= dtypei;
                r_datao   <= datai;
              end
            end
          end
          default: begin
            r_dvo    <= 1'b1;
            r_dtypeo <= dtypei;
            r_datao  <= datai;
          end
        endcase
      end
    end
  end

  assign dvo      = r_dvo;
  assign dtypeo   = r_dtypeo;
  assign datao    = r_datao;
  assign out_cols = r_out_cols;
  assign out_rows = r_out_rows;

endmodule

// File: tb/tb_imager_crop.sv
// Bench for imager_crop: frames are built row by row, the expected output
// stream is derived from the window rules, and a monitor checks every cycle.
`timescale 1ns/1ps
`ifndef DTYPE_WIDTH
`define DTYPE_WIDTH 4
`endif
`ifndef DTYPE_FRAME_START
`define DTYPE_FRAME_START  4'h1
`define DTYPE_FRAME_END    4'h2
`define DTYPE_ROW_START    4'h3
`define DTYPE_ROW_END      4'h4
`define DTYPE_PIXEL        4'h5
`define DTYPE_HEADER_START 4'h6
`define DTYPE_HEADER       4'h7
`define DTYPE_HEADER_END   4'h8
`endif

module tb_imager_crop;
  localparam int DW = 16;
  localparam int MW = 16;
  localparam int TW = `DTYPE_WIDTH;
  localparam int EW = TW + DW;

  logic          clk = 1'b0;
  logic          resetb = 1'b0;
  logic          enable = 1'b0;
  logic [MW-1:0] col_start = '0;
  logic [MW-1:0] row_start = '0;
  logic [MW-1:0] num_cols = '0;
  logic [MW-1:0] num_rows = '0;
  logic          dvi = 1'b0;
  logic [TW-1:0] dtypei = '0;
  logic [DW-1:0] datai = '0;
  logic          dvo;
  logic [TW-1:0] dtypeo;
  logic [DW-1:0] datao;
  logic [MW-1:0] out_cols;
  logic [MW-1:0] out_rows;

  int            n_vec = 0;
  int            n_bad = 0;
  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] exp_tok;
  logic          prev_dvi = 1'b0;
  int            exp_cols;
  int            exp_rows;

  imager_crop #(.DATA_WIDTH(DW), .DIM_WIDTH(MW)) dut (
    .clk(clk), .resetb(resetb), .enable(enable),
    .col_start(col_start), .row_start(row_start),
    .num_cols(num_cols), .num_rows(num_rows),
    .dvi(dvi), .dtypei(dtypei), .datai(datai),
    .dvo(dvo), .dtypeo(dtypeo), .datao(datao),
    .out_cols(out_cols), .out_rows(out_rows)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  always @(posedge clk) prev_dvi = dvi;

  initial begin
    #500000;
    $display("FAIL watchdog timeout vectors=%0d", n_vec);
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    n_vec++;
    if (dvo) begin
      if (exp_q.size() == 0) begin
        assert (1'b0) else begin
          n_bad++;
          $error("FAIL unexpected_token got=%h exp=none", {dtypeo, datao});
        end
      end else begin
        exp_tok = exp_q.pop_front();
        assert (({dtypeo, datao} === exp_tok) && prev_dvi) else begin
          n_bad++;
          $error("FAIL stream_token got=%h exp=%h in_prev_cycle=%0b", {dtypeo, datao}, exp_tok, prev_dvi);
        end
      end
    end else begin
      assert ((dtypeo === '0) && (datao === '0) && (dvo === 1'b0)) else begin
        n_bad++;
        $error("FAIL idle_outputs got=%h/%h/%b exp=0/0/0", dtypeo, datao, dvo);
      end
    end
  end

  // ---------------- driver tasks ----------------
  function automatic void expect_tok(input logic [TW-1:0] t, input logic [DW-1:0] d);
    exp_q.push_back({t, d});
  endfunction

  task automatic send(input logic [TW-1:0] t, input logic [DW-1:0] d);
    dvi = 1'b1; dtypei = t; datai = d;
    @(posedge clk); #1;
    dvi = 1'b0; dtypei = '0; datai = '0;
    if ($urandom_range(0, 3) == 0) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic check(input string tag, input logic [MW-1:0] got, input logic [MW-1:0] exp_v);
    n_vec++;
    assert (got === exp_v) else begin
      n_bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp_v);
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(posedge clk);
    @(posedge clk); #1;
    n_vec++;
    assert (exp_q.size() == 0) else begin
      n_bad++;
      $error("FAIL drain pending=%0d exp=0", exp_q.size());
      exp_q.delete();
    end
  endtask

  // Reference: a well-formed frame of rows x cols, expected output derived
  // from the window rules with plain integer arithmetic.
  task automatic run_frame(input int rows, input int cols, input int chg_cs,
                           input bit drop_last_re, input bit rnd);
    int en, cs, rs, nc, nr, kept, last, pc;
    bit rk, ck;
    logic [DW-1:0] d;
    en = int'(enable); cs = int'(col_start); rs = int'(row_start);
    nc = int'(num_cols); nr = int'(num_rows);
    kept = 0; last = 0;
    d = DW'($urandom);
    expect_tok(`DTYPE_FRAME_START, d);
    send(`DTYPE_FRAME_START, d);
    for (int r = 0; r < rows; r++) begin
      rk = (en == 0) || (nc != 0 && nr != 0 && r >= rs && r < rs + nr);
      d = DW'($urandom);
      if (rk) expect_tok(`DTYPE_ROW_START, (en != 0) ? DW'(r - rs) : d);
      send(`DTYPE_ROW_START, d);
      pc = 0;
      for (int c = 0; c < cols; c++) begin
        ck = (en == 0) || (c >= cs && c < cs + nc);
        d = rnd ? DW'($urandom) : DW'(r * 16 + c);
        if (rk && ck) begin
          expect_tok(`DTYPE_PIXEL, d);
          pc++;
        end
        send(`DTYPE_PIXEL, d);
      end
      if (rk) begin
        kept++;
        last = pc;
      end
      if (!(drop_last_re && r == rows - 1)) begin
        d = DW'($urandom);
        if (rk) expect_tok(`DTYPE_ROW_END, d);
        send(`DTYPE_ROW_END, d);
      end
      if (r == 0 && chg_cs >= 0) col_start = MW'(chg_cs);
    end
    d = DW'($urandom);
    expect_tok(`DTYPE_FRAME_END, d);
    send(`DTYPE_FRAME_END, d);
    exp_cols = last;
    exp_rows = kept;
    drain();
    check("out_cols", out_cols, MW'(exp_cols));
    check("out_rows", out_rows, MW'(exp_rows));
  endtask

  task automatic set_cfg(input logic en, input int cs, input int nc, input int rs, input int nr);
    enable = en;
    col_start = MW'(cs); num_cols = MW'(nc);
    row_start = MW'(rs); num_rows = MW'(nr);
  endtask

  // ---------------- directed + random sequence ----------------
  logic [DW-1:0] hd;

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_dvo", MW'(dvo), '0);
    check("rst_dtypeo", MW'(dtypeo), '0);
    check("rst_datao", datao, '0);
    check("rst_out_cols", out_cols, '0);
    check("rst_out_rows", out_rows, '0);
    resetb = 1'b1;
    @(posedge clk); #1;

    // row/pixel tokens outside a frame are dropped
    send(`DTYPE_ROW_START, 16'h0011);
    send(`DTYPE_PIXEL, 16'h0022);
    send(`DTYPE_ROW_END, 16'h0033);
    drain();

    // cropped 4x6 frame, pixel value row*16+col
    set_cfg(1'b1, 2, 3, 1, 2);
    run_frame(4, 6, -1, 1'b0, 1'b0);
    check("crop_cols_is_3", out_cols, 16'd3);
    check("crop_rows_is_2", out_rows, 16'd2);

    // header tokens and an unknown type pass through outside a frame
    hd = DW'($urandom); expect_tok(`DTYPE_HEADER_START, hd); send(`DTYPE_HEADER_START, hd);
    for (int i = 0; i < 3; i++) begin
      hd = DW'($urandom); expect_tok(`DTYPE_HEADER, hd); send(`DTYPE_HEADER, hd);
    end
    hd = DW'($urandom); expect_tok(`DTYPE_HEADER_END, hd); send(`DTYPE_HEADER_END, hd);
    hd = DW'($urandom); expect_tok(4'hF, hd); send(4'hF, hd);
    drain();

    // bypass
    set_cfg(1'b0, 2, 3, 1, 2);
    run_frame(4, 6, -1, 1'b0, 1'b0);
    check("bypass_cols_is_6", out_cols, 16'd6);
    check("bypass_rows_is_4", out_rows, 16'd4);

    // col_start changed mid-frame only applies to the next frame
    set_cfg(1'b1, 2, 3, 0, 4);
    run_frame(3, 6, 0, 1'b0, 1'b1);
    run_frame(3, 6, -1, 1'b0, 1'b1);

    // window starting at the top of the counter range keeps nothing
    set_cfg(1'b1, 0, 6, 16'hFFFF, 2);
    run_frame(4, 6, -1, 1'b0, 1'b1);
    check("ovf_cols_is_0", out_cols, 16'd0);
    check("ovf_rows_is_0", out_rows, 16'd0);

    // FRAME_END closes an unterminated row
    set_cfg(1'b1, 1, 2, 1, 3);
    run_frame(3, 5, -1, 1'b1, 1'b1);

    // FRAME_START while already in a frame restarts it
    set_cfg(1'b0, 0, 1, 0, 1);
    hd = DW'($urandom); expect_tok(`DTYPE_FRAME_START, hd); send(`DTYPE_FRAME_START, hd);
    hd = DW'($urandom); expect_tok(`DTYPE_ROW_START, hd); send(`DTYPE_ROW_START, hd);
    hd = DW'($urandom); expect_tok(`DTYPE_PIXEL, hd); send(`DTYPE_PIXEL, hd);
    hd = DW'($urandom); expect_tok(`DTYPE_PIXEL, hd); send(`DTYPE_PIXEL, hd);
    run_frame(2, 3, -1, 1'b0, 1'b1);
    check("restart_cols_is_3", out_cols, 16'd3);
    check("restart_rows_is_2", out_rows, 16'd2);

    // reset in the middle of a row
    set_cfg(1'b1, 1, 2, 0, 2);
    hd = DW'($urandom); expect_tok(`DTYPE_FRAME_START, hd); send(`DTYPE_FRAME_START, hd);
    hd = DW'($urandom); expect_tok(`DTYPE_ROW_START, 16'h0000); send(`DTYPE_ROW_START, hd);
    send(`DTYPE_PIXEL, 16'h0100);
    expect_tok(`DTYPE_PIXEL, 16'h0101); send(`DTYPE_PIXEL, 16'h0101);
    drain();
    resetb = 1'b0;
    #2;
    check("midrst_dvo", MW'(dvo), '0);
    check("midrst_datao", datao, '0);
    check("midrst_out_cols", out_cols, '0);
    check("midrst_out_rows", out_rows, '0);
    @(posedge clk); #1;
    resetb = 1'b1;
    @(posedge clk); #1;
    send(`DTYPE_PIXEL, 16'h0102);
    send(`DTYPE_PIXEL, 16'h0103);
    send(`DTYPE_ROW_END, 16'h0104);
    send(`DTYPE_ROW_START, 16'h0105);
    send(`DTYPE_PIXEL, 16'h0106);
    send(`DTYPE_ROW_END, 16'h0107);
    expect_tok(`DTYPE_FRAME_END, 16'h0108); send(`DTYPE_FRAME_END, 16'h0108);
    drain();
    run_frame(3, 4, -1, 1'b0, 1'b1);
    check("after_rst_cols_is_2", out_cols, 16'd2);
    check("after_rst_rows_is_2", out_rows, 16'd2);

    // random windows and frame sizes
    for (int k = 0; k < 10; k++) begin
      set_cfg(1'($urandom_range(0, 1)), $urandom_range(0, 7), $urandom_range(0, 7),
              $urandom_range(0, 5), $urandom_range(0, 5));
      run_frame($urandom_range(1, 6), $urandom_range(1, 8), -1, 1'b0, 1'b1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
